uart_rx_fifo: RTL and testbench

//   Parametrised UART receiver with oversampled bit recovery, runtime frame configuration and a

---
 rtl/uart_rx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled bit recovery, per-frame configuration latching
// and a first-word-fall-through receive FIFO tagging each byte with error flags.
module uart_rx_fifo #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             baud_tick,
    input  logic             serial_in,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_use_parity,
    input  logic             cfg_parity_odd,
    input  logic             cfg_two_stop,
    input  logic             rd_en,
    input  logic             clr_overrun,
    output logic [7:0]       rd_data,
    output logic             rd_parity_err,
    output logic             rd_frame_err,
    output logic             rx_empty,
    output logic             rx_full,
    output logic [CNT_W-1:0] rx_count,
    output logic             overrun,
    output logic             receiving
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] SAMPLE_PT = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      sync_reg;
    logic            line;
    logic            line_prev_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic [2:0]      bit_idx_reg;
    logic            stop_idx_reg;
    logic [7:0]      data_reg;
    logic            perr_reg;
    logic            ferr_reg;
    logic [1:0]      cfg_bits_reg;
    logic            cfg_par_reg;
    logic            cfg_odd_reg;
    logic            cfg_two_reg;
    logic            sample_pt;
    logic [2:0]      last_idx;
    logic            start_frame;
    logic            push_frame;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic            overrun_reg;
    logic            do_pop;
    logic            do_push;
    logic            fifo_full;

    // Two-flop synchroniser for the raw RX pin; idles high out of reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset)
                    if (reset) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= serial_in;
            end else begin : g_rest
                always_ff @(posedge clk or posedge reset)
                    if (reset) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign line      = sync_reg[1];
    assign sample_pt = baud_tick && (tick_cnt_reg == SAMPLE_PT);
    // Index of the final data bit: 00 -> 8 bits (7), 11 -> 5 bits (4).
    assign last_idx  = 3'd7 - {1'b0, cfg_bits_reg};

    // FSM state register.
    always_ff @(posedge clk or posedge reset)
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;

    // FSM next-state logic; only baud_tick cycles can move the machine.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (baud_tick && line_prev_reg && !line) state_next = START;
            START:  if (sample_pt) state_next = line ? IDLE : DATA;
            DATA:   if (sample_pt && bit_idx_reg == last_idx)
                        state_next = cfg_par_reg ? PARITY : STOP;
            PARITY: if (sample_pt) state_next = STOP;
            STOP:   if (sample_pt && (!cfg_two_reg || stop_idx_reg)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: frame start strobe and push strobe at the last stop sample.
    always_comb begin
        start_frame = (state_reg == IDLE) && (state_next == START);
        push_frame  = (state_reg == STOP) && sample_pt && (!cfg_two_reg || stop_idx_reg);
        receiving   = (state_reg != IDLE);
    end

    // Bit-recovery datapath: tick phase, data assembly, error accumulation, config latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_prev_reg <= 1'b1;
            tick_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            stop_idx_reg  <= 1'b0;
            data_reg      <= '0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            cfg_bits_reg  <= '0;
            cfg_par_reg   <= 1'b0;
            cfg_odd_reg   <= 1'b0;
            cfg_two_reg   <= 1'b0;
        end else if (baud_tick) begin
            line_prev_reg <= line;
            if (start_frame) begin
                tick_cnt_reg <= '0;
                bit_idx_reg  <= '0;
                stop_idx_reg <= 1'b0;
                data_reg     <= '0;
                perr_reg     <= 1'b0;
                ferr_reg     <= 1'b0;
                cfg_bits_reg <= cfg_data_bits;
                cfg_par_reg  <= cfg_use_parity;
                cfg_odd_reg  <= cfg_parity_odd;
                cfg_two_reg  <= cfg_two_stop;
            end else begin
                tick_cnt_reg <= (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
                if (sample_pt) begin
                    case (state_reg)
                        DATA: begin
                            data_reg[bit_idx_reg] <= line;
                            bit_idx_reg           <= bit_idx_reg + 1'b1;
                        end
                        PARITY: perr_reg <= ((^data_reg) ^ line) != cfg_odd_reg;
                        STOP: begin
                            ferr_reg     <= ferr_reg | ~line;
                            stop_idx_reg <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
    assign do_pop    = rd_en && (count_reg != '0);
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign do_push   = push_frame && (!fifo_full || do_pop);

    // FIFO storage; the current stop sample is folded into the stored frame error.
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr_reg] <= {data_reg, perr_reg, ferr_reg | ~line};

    // FIFO pointers, occupancy and sticky overrun (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
            if (push_frame && !do_push) overrun_reg <= 1'b1;
            else if (clr_overrun)       overrun_reg <= 1'b0;
        end
    end

    // Head entry is forced to zero while empty so outputs are defined after reset.
    always_comb begin
        rx_empty      = (count_reg == '0);
        rx_full       = fifo_full;
        rx_count      = count_reg;
        overrun       = overrun_reg;
        rd_data       = rx_empty ? 8'h00 : mem[rd_ptr_reg][9:2];
        rd_parity_err = rx_empty ? 1'b0  : mem[rd_ptr_reg][1];
        rd_frame_err  = rx_empty ? 1'b0  : mem[rd_ptr_reg][0];
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: baud_tick every second clock, 16x oversampling.
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 32; // 16 ticks * 2 clocks per tick

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       serial_in = 1'b1;
    logic [1:0] cfg_data_bits = 2'b00;
    logic       cfg_use_parity = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_two_stop = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       rd_frame_err;
    logic       rx_empty;
    logic       rx_full;
    logic [3:0] rx_count;
    logic       overrun;
    logic       receiving;

    int checks = 0;
    int failures = 0;

    uart_rx_fifo #(.OVERSAMPLE(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .serial_in(serial_in),
        .cfg_data_bits(cfg_data_bits), .cfg_use_parity(cfg_use_parity),
        .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
        .rd_en(rd_en), .clr_overrun(clr_overrun), .rd_data(rd_data),
        .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
        .overrun(overrun), .receiving(receiving)
    );

    always #5 clk = ~clk;
    always @(posedge clk) baud_tick <= ~baud_tick;

    // All driving happens just after a falling edge.
    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input int nstop, input logic stop2);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(1'b1);
        if (nstop == 2) drive_bit(stop2);
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
        $display("frame sent data=%h bits=%0d count=%0d", d, nbits, rx_count);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (rd_parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", rd_parity_err); end
        checks++; if (rd_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", rd_frame_err); end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", rx_empty); end
        checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", rx_full); end
        checks++; if (rx_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rx_count); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (receiving !== 1'b0) begin failures++; $display("FAIL reset_receiving got=%b exp=0", receiving); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_8n1();
        cfg_data_bits = 2'b00; cfg_use_parity = 1'b0; cfg_two_stop = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
        checks++; if (rx_count !== 4'd1) begin failures++; $display("FAIL 8n1_count got=%0d exp=1", rx_count); end
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL 8n1_data got=%h exp=a5", rd_data); end
        checks++; if (rd_parity_err !== 1'b0) begin failures++; $display("FAIL 8n1_perr got=%b exp=0", rd_parity_err); end
        checks++; if (rd_frame_err !== 1'b0) begin failures++; $display("FAIL 8n1_ferr got=%b exp=0", rd_frame_err); end
        checks++; if (receiving !== 1'b0) begin failures++; $display("FAIL 8n1_receiving got=%b exp=0", receiving); end
        pop();
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL 8n1_empty_after_pop got=%b exp=1", rx_empty); end
    endtask

    task automatic test_7e1_parity();
        // 0x55 in 7 bits has four ones: correct even parity bit is 0, send 1.
        cfg_data_bits = 2'b01; cfg_use_parity = 1'b1; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
        send_frame(8'h55, 7, 1'b1, 1'b1, 1, 1'b1);
        checks++; if (rd_data !== 8'h55) begin failures++; $display("FAIL 7e1_data got=%h exp=55", rd_data); end
        checks++; if (rd_parity_err !== 1'b1) begin failures++; $display("FAIL 7e1_perr got=%b exp=1", rd_parity_err); end
        checks++; if (rd_frame_err !== 1'b0) begin failures++; $display("FAIL 7e1_ferr got=%b exp=0", rd_frame_err); end
        pop();
        // Same frame with the correct parity bit.
        send_frame(8'h55, 7, 1'b1, 1'b0, 1, 1'b1);
        checks++; if (rd_parity_err !== 1'b0) begin failures++; $display("FAIL 7e1_good_perr got=%b exp=0", rd_parity_err); end
        pop();
    endtask

    task automatic test_5o2_frame();
        // 0x13 = 10011 has three ones: correct odd parity bit is 0.
        cfg_data_bits = 2'b11; cfg_use_parity = 1'b1; cfg_parity_odd = 1'b1; cfg_two_stop = 1'b1;
        send_frame(8'h13, 5, 1'b1, 1'b0, 2, 1'b0);
        checks++; if (rd_data !== 8'h13) begin failures++; $display("FAIL 5o2_data got=%h exp=13", rd_data); end
        checks++; if (rd_frame_err !== 1'b1) begin failures++; $display("FAIL 5o2_ferr got=%b exp=1", rd_frame_err); end
        checks++; if (rd_parity_err !== 1'b0) begin failures++; $display("FAIL 5o2_perr got=%b exp=0", rd_parity_err); end
        checks++; if (receiving !== 1'b0) begin failures++; $display("FAIL 5o2_receiving got=%b exp=0", receiving); end
        pop();
    endtask

    task automatic test_glitch();
        cfg_data_bits = 2'b00; cfg_use_parity = 1'b0; cfg_two_stop = 1'b0;
        serial_in = 1'b0;
        repeat (8) @(negedge clk);
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (receiving !== 1'b1) begin failures++; $display("FAIL glitch_receiving_mid got=%b exp=1", receiving); end
        repeat (3 * BIT_CLKS) @(negedge clk);
        checks++; if (rx_count !== 4'd0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", rx_count); end
        checks++; if (receiving !== 1'b0) begin failures++; $display("FAIL glitch_receiving got=%b exp=0", receiving); end
        $display("glitch checked count=%0d", rx_count);
    endtask

    task automatic test_fifo_overrun();
        cfg_data_bits = 2'b00; cfg_use_parity = 1'b0; cfg_two_stop = 1'b0;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1, 1'b1);
        checks++; if (rx_full !== 1'b1) begin failures++; $display("FAIL fifo_full got=%b exp=1", rx_full); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL fifo_overrun got=%b exp=1", overrun); end
        checks++; if (rx_count !== 4'd8) begin failures++; $display("FAIL fifo_count got=%0d exp=8", rx_count); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data !== 8'(i)) begin failures++; $display("FAIL fifo_pop%0d got=%h exp=%h", i, rd_data, 8'(i)); end
            pop();
            $display("popped entry %0d count=%0d", i, rx_count);
        end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL fifo_empty got=%b exp=1", rx_empty); end
        pop();
        checks++; if (rx_count !== 4'd0) begin failures++; $display("FAIL fifo_underflow_count got=%0d exp=0", rx_count); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        checks++; if (rx_count !== 4'd2) begin failures++; $display("FAIL midreset_pre_count got=%0d exp=2", rx_count); end
        checks++; if (receiving !== 1'b1) begin failures++; $display("FAIL midreset_pre_receiving got=%b exp=1", receiving); end
        reset = 1'b1;
        #1;
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL midreset_empty got=%b exp=1", rx_empty); end
        checks++; if (rx_count !== 4'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", rx_count); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midreset_overrun got=%b exp=0", overrun); end
        checks++; if (receiving !== 1'b0) begin failures++; $display("FAIL midreset_receiving got=%b exp=0", receiving); end
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4 * BIT_CLKS) @(negedge clk);
        checks++; if (rx_count !== 4'd0) begin failures++; $display("FAIL midreset_post_count got=%0d exp=0", rx_count); end
        $display("reset mid-frame checked");
    endtask

    task automatic test_overrun_clear();
        for (int i = 0; i < 9; i++) send_frame(8'(8'h40 + i), 8, 1'b0, 1'b0, 1, 1'b1);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL clr_pre_overrun got=%b exp=1", overrun); end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL clr_overrun got=%b exp=0", overrun); end
        checks++; if (rd_data !== 8'h40) begin failures++; $display("FAIL clr_head got=%h exp=40", rd_data); end
        do_reset();
        $display("overrun clear checked");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_7e1_parity();
        test_5o2_frame();
        test_glitch();
        test_fifo_overrun();
        test_reset_mid_frame();
        test_overrun_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
